// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared state encodings, reset defaults and config check for the MBIST clock divider
package clk_div_pkg;

    localparam int DEFAULT_DIV  = 4;
    localparam int DEFAULT_HIGH = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    // A usable period needs at least one high and one low cycle.
    function automatic logic cfg_is_valid(input logic [31:0] div, input logic [31:0] high);
        return (div >= 32'd2) && (high >= 32'd1) && (high < div);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// rtl/clk_div_core.sv - period counter, wrap detect and registered divided clock / tick
module clk_div_core #(
    parameter int CNT_W    = 8,
    parameter int DEF_DIV  = 4,
    parameter int DEF_HIGH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             active_next,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    input  logic [CNT_W-1:0] load_high,
    output logic             wrap,
    output logic             clk_div_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] high_act;
    logic [CNT_W-1:0] high_eff;

    always_comb begin
        wrap     = advance && (cnt == div_act - CNT_W'(1));
        cnt_nxt  = (advance && !wrap) ? cnt + CNT_W'(1) : '0;
        // A config loading on this edge already shapes the first cycle of the new period.
        high_eff = load ? load_high : high_act;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            div_act     <= CNT_W'(DEF_DIV);
            high_act    <= CNT_W'(DEF_HIGH);
            clk_div_out <= 1'b0;
            tick        <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (load) begin
                div_act  <= load_div;
                high_act <= load_high;
            end
            clk_div_out <= active_next && (cnt_nxt < high_eff);
            tick        <= active_next && (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// rtl/clk_div_sched.sv - run/stop FSM, pending config slot and handshake around the divider core
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int DEF_DIV  = DEFAULT_DIV,
    parameter int DEF_HIGH = DEFAULT_HIGH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_div_out,
    output logic             tick,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             pend_vld;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_high;
    logic             wrap;
    logic             advance;
    logic             active_next;
    logic             apply;
    logic             accept;
    logic             cfg_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (en) state_nxt = S_RUN;
            S_RUN:  if (!en) state_nxt = wrap ? S_IDLE : S_STOP;
            S_STOP: if (wrap) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        advance     = (state != S_IDLE);
        active_next = (state_nxt != S_IDLE);
        cfg_ready   = ~pend_vld;
        accept      = cfg_valid && cfg_ready;
        cfg_ok      = cfg_is_valid(32'(cfg_div), 32'(cfg_high));
        // pend_vld is only set after the accepting edge, so an accept on a wrap waits for the next wrap.
        apply       = pend_vld && ((state == S_IDLE) || wrap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld  <= 1'b0;
            pend_div  <= '0;
            pend_high <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= accept && !cfg_ok;
            if (apply) begin
                pend_vld <= 1'b0;
            end else if (accept && cfg_ok) begin
                pend_vld  <= 1'b1;
                pend_div  <= cfg_div;
                pend_high <= cfg_high;
            end
        end
    end

    clk_div_core #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV),
        .DEF_HIGH(DEF_HIGH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance    (advance),
        .active_next(active_next),
        .load       (apply),
        .load_div   (pend_div),
        .load_high  (pend_high),
        .wrap       (wrap),
        .clk_div_out(clk_div_out),
        .tick       (tick)
    );

endmodule

// File: tb/tb_clk_div_sched.sv
// tb/tb_clk_div_sched.sv - directed self-checking bench for clk_div_sched
module tb_clk_div_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_div = 8'd0;
    logic [7:0] cfg_high = 8'd0;
    logic       cfg_err;
    logic       clk_div_out;
    logic       tick;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clk_div_sched #(
        .CNT_W   (8),
        .DEF_DIV (4),
        .DEF_HIGH(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .clk_div_out(clk_div_out),
        .tick       (tick),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        en        = 1'b0;
        cfg_valid = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic offer(input logic [7:0] d, input logic [7:0] h);
        cfg_div   = d;
        cfg_high  = h;
        cfg_valid = 1'b1;
    endtask

    // Vectors are MSB-first: bit n-1 is the first cycle after the next edge.
    task automatic expect_seq(input string tag, input int n,
                              input logic [31:0] o, input logic [31:0] t,
                              input logic [31:0] r, input logic [31:0] e,
                              input logic [31:0] b);
        for (int i = 0; i < n; i++) begin
            logic fire;
            fire = cfg_valid && cfg_ready;
            step();
            if (fire) cfg_valid = 1'b0;
            chk($sformatf("%s[%0d].out", tag, i), 32'(clk_div_out), 32'(o[n-1-i]));
            chk($sformatf("%s[%0d].tick", tag, i), 32'(tick), 32'(t[n-1-i]));
            chk($sformatf("%s[%0d].ready", tag, i), 32'(cfg_ready), 32'(r[n-1-i]));
            chk($sformatf("%s[%0d].err", tag, i), 32'(cfg_err), 32'(e[n-1-i]));
            chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(b[n-1-i]));
        end
    endtask

    initial begin
        // 1: reset values, then default 1100 pattern
        do_reset();
        chk("rst.out", 32'(clk_div_out), 32'd0);
        chk("rst.tick", 32'(tick), 32'd0);
        chk("rst.ready", 32'(cfg_ready), 32'd1);
        chk("rst.err", 32'(cfg_err), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        en = 1'b1;
        expect_seq("t1", 8, 32'b11001100, 32'b10001000, 32'hFF, 32'h0, 32'hFF);

        // 2: div=3 high=1 offered at cnt=1, applies at the next wrap
        expect_seq("t2a", 2, 32'b11, 32'b10, 32'b11, 32'h0, 32'b11);
        offer(8'd3, 8'd1);
        expect_seq("t2b", 9, 32'b001001001, 32'b001001001, 32'b001111111, 32'h0, 32'h1FF);

        // 3: rejected configs pulse cfg_err and leave the pattern alone
        do_reset();
        en = 1'b1;
        expect_seq("t3a", 1, 32'b1, 32'b1, 32'b1, 32'h0, 32'b1);
        offer(8'd1, 8'd1);
        expect_seq("t3b", 2, 32'b10, 32'b00, 32'b11, 32'b10, 32'b11);
        offer(8'd5, 8'd5);
        expect_seq("t3c", 6, 32'b011001, 32'b010001, 32'h3F, 32'b100000, 32'h3F);

        // 4: stop at period boundary, en ignored in STOP, direct RUN->IDLE at wrap
        do_reset();
        en = 1'b1;
        expect_seq("t4a", 1, 32'b1, 32'b1, 32'b1, 32'h0, 32'b1);
        en = 1'b0;
        expect_seq("t4b", 5, 32'b10000, 32'b00000, 32'h1F, 32'h0, 32'b11100);
        en = 1'b1;
        expect_seq("t4c", 1, 32'b1, 32'b1, 32'b1, 32'h0, 32'b1);
        en = 1'b0;
        expect_seq("t4d", 1, 32'b1, 32'b0, 32'b1, 32'h0, 32'b1);
        en = 1'b1;
        expect_seq("t4e", 4, 32'b0001, 32'b0001, 32'hF, 32'h0, 32'b1101);
        expect_seq("t4f", 3, 32'b100, 32'b000, 32'b111, 32'h0, 32'b111);
        en = 1'b0;
        expect_seq("t4g", 2, 32'b00, 32'b00, 32'b11, 32'h0, 32'b00);

        // 5: back-to-back configs, second stalls until the first applies
        do_reset();
        en = 1'b1;
        expect_seq("t5a", 1, 32'b1, 32'b1, 32'b1, 32'h0, 32'b1);
        offer(8'd6, 8'd3);
        expect_seq("t5b", 1, 32'b1, 32'b0, 32'b0, 32'h0, 32'b1);
        offer(8'd2, 8'd1);
        expect_seq("t5c", 12, 32'b001110001010, 32'b001000001010, 32'b001000001111, 32'h0, 32'hFFF);

        // 6: async reset mid-period discards the pending config
        do_reset();
        en = 1'b1;
        expect_seq("t6a", 1, 32'b1, 32'b1, 32'b1, 32'h0, 32'b1);
        offer(8'd3, 8'd1);
        expect_seq("t6b", 1, 32'b1, 32'b0, 32'b0, 32'h0, 32'b1);
        rst_n = 1'b0;
        #1;
        chk("t6.rst.out", 32'(clk_div_out), 32'd0);
        chk("t6.rst.tick", 32'(tick), 32'd0);
        chk("t6.rst.ready", 32'(cfg_ready), 32'd1);
        chk("t6.rst.busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        expect_seq("t6c", 9, 32'b110011001, 32'b100010001, 32'h1FF, 32'h0, 32'h1FF);

        // 7: config taken in IDLE applies on the same edge that starts RUN
        do_reset();
        offer(8'd3, 8'd1);
        expect_seq("t7a", 1, 32'b0, 32'b0, 32'b0, 32'h0, 32'b0);
        en = 1'b1;
        expect_seq("t7b", 4, 32'b1001, 32'b1001, 32'hF, 32'h0, 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
